// File: rtl/mem_access_stage_pkg.sv
// Shared types for the M-stage data-bus controller: bus request/response
// bundles, access size and FSM state enums, store lane helpers.
package mem_access_stage_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } mstate_t;

  function automatic logic [3:0] st_strobe(
    input msize_t     sz,
    input logic [1:0] a
  );
    case (sz)
      MSIZE1:  st_strobe = 4'b0001 << a;
      MSIZE2:  st_strobe = 4'b0011 << {a[1], 1'b0};
      default: st_strobe = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] st_repl(
    input msize_t      sz,
    input logic [31:0] w
  );
    case (sz)
      MSIZE1:  st_repl = {4{w[7:0]}};
      MSIZE2:  st_repl = {2{w[15:0]}};
      default: st_repl = w;
    endcase
  endfunction

  function automatic logic misaligned(
    input msize_t     sz,
    input logic [1:0] a
  );
    case (sz)
      MSIZE1:  misaligned = 1'b0;
      MSIZE2:  misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Load data lane shift plus sign/zero extension.
// Ports: i_raw bus word, i_off byte offset, i_size, i_uns -> o_data.
module mem_load_ext
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_off,
  input  msize_t      i_size,
  input  logic        i_uns,
  output logic [31:0] o_data
);

  logic [15:0] w_sh;

  always_comb begin
    w_sh   = 16'(i_raw >> {i_off, 3'b000});
    o_data = i_raw;
    unique case (1'b1)
      (i_size == MSIZE1):
        o_data = {{24{~i_uns & w_sh[7]}}, w_sh[7:0]};
      (i_size == MSIZE2):
        o_data = {{16{~i_uns & w_sh[15]}}, w_sh[15:0]};
      default:
        o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// M-stage data-bus controller: one dbus transaction per load/store,
// valid/addr_ok/data_ok handshake, pipeline stall, aligned load data.
// Ports: clk, reset (sync, high); M-stage request (mem_*, addr, wdata);
// advance/flush from hazard unit; dreq/dresp bus; stall_m, done,
// rdata_m, exc_adel/exc_ades to pipeline.
// Option: MEM_ADDR_CHECK_EN enables misaligned-address exceptions.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int RESET_PC_UNUSED_W = 0,
  parameter int DATA_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              advance,
  input  logic              flush,
  output dbus_req_t         dreq,
  input  dbus_resp_t        dresp,
  output logic              stall_m,
  output logic              done,
  output logic [DATA_W-1:0] rdata_m,
  output logic              exc_adel,
  output logic              exc_ades
);

  if (RESET_PC_UNUSED_W != 0) begin : g_pad_must_be_zero
  end

  mstate_t     r_state;
  mstate_t     w_nstate;
  logic [31:0] r_addr;
  msize_t      r_size;
  logic [3:0]  r_strb;
  logic [31:0] r_data;
  logic        r_uns;
  logic        r_load;
  logic        r_aok;
  logic [31:0] r_raw;
  logic        r_mis;

  logic        w_access;
  msize_t      w_size;
  logic        w_mis;
  logic        w_cap;
  logic        w_naok;
  logic [1:0]  w_alo;
  logic [31:0] w_ext;

  assign w_access = mem_valid & (mem_read | mem_write) & ~flush;
  assign w_size   = msize_t'(mem_size);

`ifdef MEM_ADDR_CHECK_EN
  assign w_mis = misaligned(w_size, addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_nstate = r_state;
    w_cap    = 1'b0;
    w_naok   = r_aok;
    unique case (r_state)
      S_IDLE: begin
        w_naok = 1'b0;
        if (w_access)
          w_nstate = w_mis ? S_HOLD : S_REQ;
      end
      S_REQ: begin
        if (dresp.addr_ok & dresp.data_ok) begin
          w_cap    = 1'b1;
          w_nstate = flush ? S_IDLE : S_HOLD;
        end else if (dresp.addr_ok) begin
          w_naok   = 1'b1;
          w_nstate = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          w_nstate = S_DRAIN;
        end
      end
      S_WAIT: begin
        if (dresp.data_ok) begin
          w_cap    = 1'b1;
          w_nstate = flush ? S_IDLE : S_HOLD;
        end else if (flush) begin
          w_naok   = 1'b1;
          w_nstate = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush | advance)
          w_nstate = S_IDLE;
      end
      S_DRAIN: begin
        // Killed transaction: finish the handshake, discard the data.
        if (r_aok) begin
          if (dresp.data_ok)
            w_nstate = S_IDLE;
        end else if (dresp.addr_ok & dresp.data_ok) begin
          w_nstate = S_IDLE;
        end else if (dresp.addr_ok) begin
          w_naok = 1'b1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= MSIZE1;
      r_strb  <= '0;
      r_data  <= '0;
      r_uns   <= 1'b0;
      r_load  <= 1'b0;
      r_aok   <= 1'b0;
      r_raw   <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_aok   <= w_naok;
      if (r_state == S_IDLE && w_access) begin
        r_addr <= addr;
        r_size <= w_size;
        r_strb <= mem_write
                  ? st_strobe(w_size, addr[1:0])
                  : 4'h0;
        r_data <= st_repl(w_size, wdata);
        r_uns  <= mem_unsigned;
        r_load <= mem_read;
        r_mis  <= w_mis;
      end
      if (w_cap)
        r_raw <= dresp.data;
    end
  end

  mem_load_ext u_ext (
    .i_raw  (r_raw),
    .i_off  (r_addr[1:0]),
    .i_size (r_size),
    .i_uns  (r_uns),
    .o_data (w_ext)
  );

  // Bus address is naturally aligned for half/word.
  always_comb begin
    case (r_size)
      MSIZE1:  w_alo = r_addr[1:0];
      MSIZE2:  w_alo = {r_addr[1], 1'b0};
      default: w_alo = 2'b00;
    endcase
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = (r_state == S_REQ)
                | ((r_state == S_DRAIN) & ~r_aok);
    dreq.addr   = {r_addr[31:2], w_alo};
    dreq.size   = r_size;
    dreq.strobe = r_strb;
    dreq.data   = r_data;
  end

  always_comb begin
    stall_m = 1'b0;
    unique case (r_state)
      S_IDLE:  stall_m = w_access;
      S_REQ,
      S_WAIT,
      S_DRAIN: stall_m = 1'b1;
      default: stall_m = 1'b0;
    endcase
  end

  logic w_hold;
  assign w_hold  = (r_state == S_HOLD) & ~flush;
  assign done    = w_hold;
  assign rdata_m = (r_state == S_HOLD) & r_load & ~r_mis
                   ? w_ext : '0;

`ifdef MEM_ADDR_CHECK_EN
  assign exc_adel = w_hold & r_mis & r_load;
  assign exc_ades = w_hold & r_mis & ~r_load;
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Bus responses are driven by hand; expected values are precomputed.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_read, mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr, wdata;
  logic        advance, flush;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall_m, done;
  logic [31:0] rdata_m;
  logic        exc_adel, exc_ades;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .advance      (advance),
    .flush        (flush),
    .dreq         (dreq),
    .dresp        (dresp),
    .stall_m      (stall_m),
    .done         (done),
    .rdata_m      (rdata_m),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mem_valid    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    addr         = '0;
    wdata        = '0;
    advance      = 1'b0;
    flush        = 1'b0;
    dresp        = '0;
  endtask

  task automatic put(input logic rd, input logic wr,
                     input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
    mem_valid    = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = u;
    addr         = a;
    wdata        = wd;
  endtask

  task automatic retire();
    advance   = 1'b1;
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
    advance = 1'b0;
    chk("retire_done", done, 0);
    chk("retire_stall", stall_m, 0);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_valid"}, dreq.valid, 0);
    chk({tag, "_stall"}, stall_m, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata"}, rdata_m, 0);
    chk({tag, "_exc"}, {exc_adel, exc_ades}, 0);
  endtask

  // Load answered in first REQ cycle.
  task automatic ld1(input string tag, input logic [1:0] sz,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] bus, input logic [31:0] exp_a,
                     input logic [31:0] exp_d);
    put(1'b1, 1'b0, sz, u, a, 32'h0);
    #1;
    chk({tag, "_st_idle"}, stall_m, 1);
    chk({tag, "_v_idle"}, dreq.valid, 0);
    step();
    chk({tag, "_st_req"}, stall_m, 1);
    chk({tag, "_v_req"}, dreq.valid, 1);
    chk({tag, "_addr"}, dreq.addr, exp_a);
    chk({tag, "_strb"}, dreq.strobe, 0);
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: bus};
    step();
    dresp = '0;
    chk({tag, "_st_hold"}, stall_m, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_rdata"}, rdata_m, exp_d);
    retire();
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    zero_outs("rst");

    ld1("lw", 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF,
        32'h8000_0004, 32'hDEAD_BEEF);
    ld1("lb", 2'd0, 1'b0, 32'h0000_1003, 32'h8011_2233,
        32'h0000_1003, 32'hFFFF_FF80);
    ld1("lbu", 2'd0, 1'b1, 32'h0000_1003, 32'h8011_2233,
        32'h0000_1003, 32'h0000_0080);
    ld1("lhu", 2'd1, 1'b1, 32'h0000_2002, 32'h8765_4321,
        32'h0000_2002, 32'h0000_8765);

    // SH lane placement.
    put(1'b0, 1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'h1234_ABCD);
    step();
    chk("sh_valid", dreq.valid, 1);
    chk("sh_strb", dreq.strobe, 32'hC);
    chk("sh_data", dreq.data, 32'hABCD_ABCD);
    chk("sh_size", dreq.size, 1);
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hFFFF_FFFF};
    step();
    dresp = '0;
    chk("sh_done", done, 1);
    chk("sh_rdata", rdata_m, 0);
    retire();

    // SB lane placement.
    put(1'b0, 1'b1, 2'd0, 1'b0, 32'h1000_0001, 32'h0000_00A5);
    step();
    chk("sb_strb", dreq.strobe, 32'h2);
    chk("sb_data", dreq.data, 32'hA5A5_A5A5);
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    step();
    dresp = '0;
    retire();

    // LH with delayed addr_ok and data_ok.
    put(1'b1, 1'b0, 2'd1, 1'b0, 32'h2000_0006, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("dly_valid", dreq.valid, 1);
      chk("dly_addr", dreq.addr, 32'h2000_0006);
      chk("dly_size", dreq.size, 1);
      step();
    end
    dresp.addr_ok = 1'b1;
    #1;
    chk("dly_valid4", dreq.valid, 1);
    step();
    dresp = '0;
    chk("dly_wait_v", dreq.valid, 0);
    chk("dly_wait_st", stall_m, 1);
    step();
    chk("dly_wait2_st", stall_m, 1);
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h8765_4321};
    step();
    dresp = '0;
    chk("dly_done", done, 1);
    chk("dly_rdata", rdata_m, 32'hFFFF_8765);
    step();
    chk("dly_hold1", done, 1);
    step();
    chk("dly_hold2", done, 1);
    chk("dly_hold2_d", rdata_m, 32'hFFFF_8765);
    retire();

    // Flush in IDLE suppresses the request.
    put(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'h0);
    flush = 1'b1;
    #1;
    chk("fidle_stall", stall_m, 0);
    step();
    chk("fidle_valid", dreq.valid, 0);
    chk("fidle_stall2", stall_m, 0);
    quiet();
    step();

    // Flush in WAIT drains the transaction.
    put(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'h0);
    step();
    dresp.addr_ok = 1'b1;
    step();
    dresp = '0;
    chk("fwait_v", dreq.valid, 0);
    flush = 1'b1;
    #1;
    chk("fwait_stall", stall_m, 1);
    chk("fwait_done", done, 0);
    step();
    quiet();
    #1;
    chk("drain_stall", stall_m, 1);
    chk("drain_v", dreq.valid, 0);
    chk("drain_done", done, 0);
    step();
    chk("drain_stall2", stall_m, 1);
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h1111_1111};
    #1;
    chk("drain_done2", done, 0);
    step();
    dresp = '0;
    chk("drain_exit_st", stall_m, 0);
    chk("drain_exit_d", done, 0);
    step();
    chk("drain_idle_d", done, 0);

    // Flush in REQ before addr_ok keeps the request up.
    put(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000_0008, 32'h0);
    step();
    flush = 1'b1;
    step();
    quiet();
    #1;
    chk("freq_v", dreq.valid, 1);
    chk("freq_addr", dreq.addr, 32'h3000_0008);
    dresp.addr_ok = 1'b1;
    step();
    dresp = '0;
    chk("freq_v2", dreq.valid, 0);
    chk("freq_st", stall_m, 1);
    dresp.data_ok = 1'b1;
    step();
    dresp = '0;
    chk("freq_exit", stall_m, 0);
    chk("freq_done", done, 0);

    // Reset mid-transaction.
    put(1'b0, 1'b1, 2'd2, 1'b0, 32'h4000_0000, 32'h1122_3344);
    step();
    chk("sw_strb", dreq.strobe, 32'hF);
    chk("sw_data", dreq.data, 32'h1122_3344);
    reset = 1'b1;
    quiet();
    step();
    reset = 1'b0;
    #1;
    zero_outs("rreq");
    chk("rreq_addr", dreq.addr, 0);

`ifdef MEM_ADDR_CHECK_EN
    put(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000_0001, 32'h0);
    #1;
    chk("mis_stall", stall_m, 1);
    chk("mis_v0", dreq.valid, 0);
    step();
    chk("mis_v1", dreq.valid, 0);
    chk("mis_done", done, 1);
    chk("mis_adel", exc_adel, 1);
    chk("mis_ades", exc_ades, 0);
    chk("mis_rdata", rdata_m, 0);
    retire();
`else
    put(1'b0, 1'b1, 2'd1, 1'b0, 32'h5000_0003, 32'h0000_5A5A);
    step();
    chk("mis_addr", dreq.addr, 32'h5000_0002);
    chk("mis_strb", dreq.strobe, 32'hC);
    chk("mis_data", dreq.data, 32'h5A5A_5A5A);
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    step();
    dresp = '0;
    chk("mis_exc", {exc_adel, exc_ades}, 0);
    retire();
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
